// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

endpackage : serial_add_pkg

// File: rtl/fa_cell.sv
// One-bit full adder: y = {carry, sum} of a + b + cin. Purely combinational.
module fa_cell (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  output logic [1:0] y
);

  assign y = {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};

endmodule : fa_cell

// File: rtl/serial_add_seq.sv
// Bit-serial N-bit adder: captures operands on start, adds one bit pair per
// clock LSB first through a single fa_cell, then pulses done with SUM/COUT.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CIN,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] SUM,
  output logic         COUT
);

  localparam int CNT_W = $clog2(N);

  sa_state_t        state;
  sa_state_t        state_nxt;
  logic [N-1:0]     a_sr;
  logic [N-1:0]     b_sr;
  logic [N-1:0]     sum_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       fa_y;
  logic             last_bit;

  fa_cell u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .y   (fa_y)
  );

  assign last_bit = (cnt == CNT_W'(N - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, regardless of the order of statements or blocks.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Moore decode only, so start can never glitch busy/done.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // NOTE: every datapath register is reset, since reset must also clear the
  // shift registers and the visible result, not just the FSM.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      SUM    <= '0;
      COUT   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= A;
            b_sr  <= B;
            carry <= CIN;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= {fa_y[0], sum_sr[N-1:1]};
          carry  <= fa_y[1];
          // Counter holds at its terminal value instead of wrapping.
          if (!last_bit) cnt <= cnt + CNT_W'(1);
          if (last_bit) begin
            SUM  <= {fa_y[0], sum_sr[N-1:1]};
            COUT <= fa_y[1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule : serial_add_seq

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: directed cases plus randomized
// operands against an arithmetic reference (A + B + CIN).
module tb_serial_add_seq;

  localparam int N = 8;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         CIN = 1'b0;
  logic         busy;
  logic         done;
  logic [N-1:0] SUM;
  logic         COUT;

  int tests = 0;
  int fails = 0;

  serial_add_seq #(.N(N)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .start (start),
    .A     (A),
    .B     (B),
    .CIN   (CIN),
    .busy  (busy),
    .done  (done),
    .SUM   (SUM),
    .COUT  (COUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
  endfunction

  // One operation from an idle DUT; optionally pulses a competing start at
  // run cycle interfere_at. Returns at the negedge after the done cycle.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                       input string tag, input int interfere_at);
    logic [N:0] exp;
    int         lat;
    bit         busy_ok;
    exp = ref_add(a, b, c);
    @(negedge CLK);
    start = 1'b1; A = a; B = b; CIN = c;
    @(posedge CLK);
    #1;
    start = 1'b0; A = N'($urandom); B = N'($urandom); CIN = 1'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    @(negedge CLK);
    while (!done && lat < 3 * N) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (lat == interfere_at) begin
        start = 1'b1; A = 8'd100; B = 8'd100; CIN = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge CLK);
      lat++;
    end
    start = 1'b0;
    tests++;
    if (busy_ok !== 1'b1) begin
      fails++; $display("FAIL %s busy_run: busy dropped before done", tag);
    end
    tests++;
    if (lat !== N) begin
      fails++; $display("FAIL %s latency: got %0d cycles expected %0d", tag, lat, N);
    end
    tests++;
    if ({COUT, SUM} !== exp) begin
      fails++; $display("FAIL %s result: got cout=%0d sum=%0d expected cout=%0d sum=%0d",
                        tag, COUT, SUM, exp[N], exp[N-1:0]);
    end
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL %s busy_done: got %0b expected 1", tag, busy);
    end
    @(negedge CLK);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || {COUT, SUM} !== exp) begin
      fails++; $display("FAIL %s after_done: got done=%0b busy=%0b sum=%0d expected 0 0 %0d",
                        tag, done, busy, SUM, exp[N-1:0]);
    end
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || SUM !== '0 || COUT !== 1'b0) begin
      fails++; $display("FAIL reset_state: got busy=%0b done=%0b sum=%0d cout=%0b expected all 0",
                        busy, done, SUM, COUT);
    end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_directed();
    do_op(8'd5,   8'd3, 1'b0, "add_5_3",     -1);
    do_op(8'd255, 8'd1, 1'b0, "overflow",    -1);
    do_op(8'd0,   8'd0, 1'b1, "cin_only",    -1);
    do_op(8'd170, 8'd85, 1'b1, "full_ripple", -1);
  endtask

  task automatic test_ignore_start();
    bit extra;
    do_op(8'd10, 8'd20, 1'b0, "ignore_start", 3);
    extra = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge CLK);
      if (done !== 1'b0 || busy !== 1'b0) extra = 1'b1;
    end
    tests++;
    if (extra !== 1'b0) begin
      fails++; $display("FAIL ignore_start_extra: got extra activity expected none");
    end
  endtask

  task automatic test_async_reset();
    bit spurious;
    @(negedge CLK);
    start = 1'b1; A = 8'd77; B = 8'd9; CIN = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (4) @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || SUM !== '0 || COUT !== 1'b0) begin
      fails++; $display("FAIL async_reset: got busy=%0b done=%0b sum=%0d cout=%0b expected all 0",
                        busy, done, SUM, COUT);
    end
    @(negedge CLK);
    RESET = 1'b0;
    spurious = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge CLK);
      if (done !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
    end
    tests++;
    if (spurious !== 1'b0) begin
      fails++; $display("FAIL reset_no_done: activity after reset expected none");
    end
    do_op(8'd1, 8'd1, 1'b0, "after_reset", -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++)
      do_op(N'($urandom), N'($urandom), 1'($urandom), "random", -1);
  endtask

  task automatic test_back_to_back();
    logic [N:0]   q[$];
    logic [N:0]   exp;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c;
    bit           exp_done;
    @(negedge CLK);
    for (int e = 0; e < 5 * (N + 2); e++) begin
      a = N'($urandom); b = N'($urandom); c = 1'($urandom);
      start = 1'b1; A = a; B = b; CIN = c;
      if (e % (N + 2) == 0) q.push_back(ref_add(a, b, c));
      @(negedge CLK);
      exp_done = (e % (N + 2) == N);
      tests++;
      if (done !== exp_done) begin
        fails++; $display("FAIL b2b_done edge %0d: got %0b expected %0b", e, done, exp_done);
      end
      if (exp_done) begin
        exp = q.pop_front();
        tests++;
        if ({COUT, SUM} !== exp) begin
          fails++; $display("FAIL b2b_result edge %0d: got cout=%0d sum=%0d expected cout=%0d sum=%0d",
                            e, COUT, SUM, exp[N], exp[N-1:0]);
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_async_reset();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_serial_add_seq
